// File: rtl/status_light_responder.sv
// GET /STATUS_LIGHT responder: consumes a fixed 4-word request and answers with ON/OFF/ERR.
// Optional partial-request timeout is built when STATUS_LIGHT_TIMEOUT_EN is defined.
module status_light_responder #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             light_on,
  output logic [CNT_W-1:0] req_count,
  output logic [CNT_W-1:0] err_count,
  output logic             timeout_pulse
);

  localparam logic [31:0] REQ_W0    = 32'h47455420;
  localparam logic [31:0] REQ_W1    = 32'h2F535441;
  localparam logic [31:0] REQ_W2    = 32'h5455535F;
  localparam logic [31:0] REQ_W3    = 32'h4C494748;
  localparam logic [31:0] REPLY_ON  = 32'h00004F4E;
  localparam logic [31:0] REPLY_OFF = 32'h004F4646;
  localparam logic [31:0] REPLY_ERR = 32'h45525221;

  typedef enum logic {
    RECV = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e           state_q;
  logic [1:0]       word_idx_q;
  logic             match_q;
  logic             rx_ready_q;
  logic             tx_valid_q;
  logic [31:0]      tx_data_q;
  logic [CNT_W-1:0] req_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [31:0] expected_word;
  logic        rx_hs;
  logic        tx_hs;
  logic        req_ok;
  logic        expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    expected_word = REQ_W0;
    unique case (word_idx_q)
      2'd0: expected_word = REQ_W0;
      2'd1: expected_word = REQ_W1;
      2'd2: expected_word = REQ_W2;
      2'd3: expected_word = REQ_W3;
    endcase
  end

  // rx_ready_q is only ever high in RECV, so an rx handshake can never coincide with RESP.
  assign rx_hs  = rx_valid & rx_ready_q;
  assign tx_hs  = tx_valid_q & tx_ready;
  assign req_ok = match_q & (rx_data == expected_word);

`ifdef STATUS_LIGHT_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic              timeout_q;

  // A handshake on the expiry cycle wins, so expiry is gated by !rx_hs.
  assign expire = (state_q == RECV) && (word_idx_q != 2'd0) && !rx_hs &&
                  (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire;
      if (state_q != RECV || word_idx_q == 2'd0 || rx_hs || expire) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign timeout_pulse = timeout_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign expire         = 1'b0;
  assign timeout_pulse  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RECV;
      word_idx_q <= 2'd0;
      match_q    <= 1'b1;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      req_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        RECV: begin
          rx_ready_q <= 1'b1;
          if (rx_hs) begin
            if (word_idx_q == 2'd3) begin
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= req_ok ? (light_on ? REPLY_ON : REPLY_OFF) : REPLY_ERR;
              word_idx_q <= 2'd0;
              match_q    <= 1'b1;
              state_q    <= RESP;
            end else begin
              word_idx_q <= word_idx_q + 2'd1;
              match_q    <= req_ok;
            end
          end else if (expire) begin
            word_idx_q <= 2'd0;
            match_q    <= 1'b1;
            err_cnt_q  <= sat_inc(err_cnt_q);
          end
        end
        RESP: begin
          if (tx_hs) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= RECV;
            if (tx_data_q == REPLY_ERR) begin
              err_cnt_q <= sat_inc(err_cnt_q);
            end else begin
              req_cnt_q <= sat_inc(req_cnt_q);
            end
          end
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign req_count = req_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: doc/status_light_responder.md
Name: status_light_responder

Overview:
Server-side application block answering the GET /STATUS_LIGHT request on the far end of the TCP link. It sits between tcp_layer's application stream ports and the board's light-status input. It parses a fixed 4-word request arriving on a 32-bit valid/ready stream. It returns a one-word ON/OFF/ERR reply on a 32-bit valid/ready stream and keeps saturating request and error counters.

Parameters:
CNT_W, 16, width of req_count and err_count
TIMEOUT_CYCLES, 1024, maximum idle cycles allowed between request words (used only with the optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  32  request word from tcp_layer (app_rx side)
rx_valid  input  1  rx_data valid
rx_ready  output  1  responder accepts rx_data this cycle
tx_data  output  32  reply word to tcp_layer (app_tx side)
tx_valid  output  1  tx_data valid
tx_ready  input  1  tcp_layer accepts tx_data
light_on  input  1  current light state, 1 = on; synchronous to clk
req_count  output  CNT_W  count of valid requests answered, saturating
err_count  output  CNT_W  count of ERR replies plus timeouts, saturating
timeout_pulse  output  1  one-cycle pulse when a partial request is discarded

Behaviour:
- Clock and reset: clk, with rst_n asynchronous and active-low. Every register clears immediately on reset, including mid-request and mid-reply. No partial state survives.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, req_count=0, err_count=0, timeout_pulse=0, state=RECV, word_idx=0, match=1.
- Expected request words, in order: W0=32'h47455420, W1=32'h2F535441, W2=32'h5455535F, W3=32'h4C494748.
- Reply words:
  - ON = 32'h00004F4E
  - OFF = 32'h004F4646
  - ERR = 32'h45525221
- States: RECV and RESP.
- RECV:
  - rx_ready=1 (registered; high from the first cycle after reset release).
  - Each cycle with rx_valid && rx_ready is a handshake. On each handshake, match <= match & (rx_data == W[word_idx]) and word_idx increments.
  - Mismatched words are still consumed. The block always consumes exactly 4 words per request.
  - On the 4th handshake:
    - rx_ready <= 0 and state goes to RESP.
    - tx_data is loaded with ON or OFF when all 4 words matched, choosing by light_on sampled on that same clock edge; otherwise it is loaded with ERR.
    - tx_valid <= 1.
    - word_idx returns to 0 and match returns to 1.
- RESP:
  - tx_valid=1. tx_data is held stable until tx_ready.
  - light_on changes during RESP have no effect on tx_data.
  - On tx_valid && tx_ready: tx_valid <= 0, rx_ready <= 1, state goes to RECV.
  - On the same edge, req_count increments for ON/OFF replies, or err_count increments for ERR.
- Latency: tx_valid rises 1 cycle after the 4th rx handshake. The next request word can be accepted 1 cycle after the tx handshake.
- Back-to-back requests are supported. rx is never accepted while in RESP, so rx and tx handshakes never coincide.
- Counters saturate at all-ones; they do not wrap.
- rx_valid low in RECV: the block holds state indefinitely unless the optional feature is enabled.

Optional Feature:
Macro STATUS_LIGHT_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RECV while word_idx != 0 and no rx handshake occurs. It clears on any rx handshake and whenever word_idx == 0.
  - When it reaches TIMEOUT_CYCLES: word_idx <= 0, match <= 1, the counter clears, timeout_pulse=1 for one cycle, and err_count increments (saturating). No reply is sent.
  - A handshake on the same edge as expiry wins: the word is accepted and no timeout occurs.
- Undefined: no idle counter is built, timeout_pulse is tied to 0, and partial requests wait indefinitely.

Test Plan:
- Reset release, light_on=1, send W0..W3 with tx_ready=1 -> tx_data=32'h00004F4E, tx_valid high 1 cycle after the 4th handshake; req_count=1.
- light_on=0, send W0..W3, hold tx_ready=0 for 5 cycles and toggle light_on to 1 during the hold -> tx_data stays 32'h004F4646; rx_ready=0 throughout; reply accepted when tx_ready rises.
- Send W0, 32'h12345678, W2, W3 -> exactly 4 words consumed, tx_data=32'h45525221; err_count=1, req_count unchanged.
- Two back-to-back valid requests with rx_valid held high -> two ON replies, req_count=2; no word is accepted in RESP.
- Assert rst_n low after W1 and again during RESP -> all outputs at reset values; a subsequent full request gets a correct reply.
- STATUS_LIGHT_TIMEOUT_EN with TIMEOUT_CYCLES=8: send W0, W1, then idle 8 cycles -> timeout_pulse for 1 cycle, err_count=1, no tx_valid; next W0..W3 returns ON/OFF normally.
